// File: rtl/pc_fetch_unit.sv
// ----------------------------------------------------------------------------
// pc_fetch_unit
//   Program-counter stage feeding the instruction ROM. Holds the PC, selects
//   the next PC from the current instruction's control decision, and injects
//   the reset / interrupt / exception vectors. PC[31] is the kernel bit;
//   interrupts and exceptions are masked while it is set. Also latches
//   external interrupt requests on their rising edge and supplies the $k0
//   return address for the register file.
//
// Ports
//   clk        in   1   system clock, all state on the rising edge
//   reset      in   1   synchronous, active-high
//   irq        in   1   level interrupt request
//   illop      in   1   current instruction is undefined
//   pcsrc      in   2   0:PC+4  1:branch  2:J/JAL  3:JR/JALR
//   br_taken   in   1   branch condition (used only when pcsrc==1)
//   br_off     in   32  sign-extended imm16, not yet shifted
//   jt         in   26  jump target field instruction[25:0]
//   rs_data    in   32  register rs value for JR/JALR
//   pc         out  32  current PC
//   rom_addr   out  31  pc[30:0]
//   pc_plus4   out  32  {pc[31], pc[30:0]+4}, JAL link value
//   intr_take  out  1   interrupt accepted this cycle (combinational)
//   excp_take  out  1   exception accepted this cycle (combinational)
//   k0_wdata   out  32  $k0 write value when a take signal is set, else 0
// ----------------------------------------------------------------------------
module pc_fetch_unit #(
    parameter logic [31:0] RESET_VEC = 32'h8000_0000,
    parameter logic [31:0] INTR_VEC  = 32'h8000_0004,
    parameter logic [31:0] EXCP_VEC  = 32'h8000_0008
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        irq,
    input  logic        illop,
    input  logic [1:0]  pcsrc,
    input  logic        br_taken,
    input  logic [31:0] br_off,
    input  logic [25:0] jt,
    input  logic [31:0] rs_data,
    output logic [31:0] pc,
    output logic [30:0] rom_addr,
    output logic [31:0] pc_plus4,
    output logic        intr_take,
    output logic        excp_take,
    output logic [31:0] k0_wdata
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned AW   = XLEN - 1;   // address bits below the kernel bit

    localparam logic [1:0] SRC_SEQ = 2'd0;
    localparam logic [1:0] SRC_BR  = 2'd1;
    localparam logic [1:0] SRC_J   = 2'd2;
    localparam logic [1:0] SRC_JR  = 2'd3;

    logic [XLEN-1:0] pc_q, pc_d;
    logic            irq_dly_q, irq_dly_d;
    logic            irq_pend_q, irq_pend_d;

    logic            kernel;
    logic            irq_rise;
    logic            excp_take_c, intr_take_c;
    logic [AW-1:0]   seq_lo;
    logic [AW-1:0]   br_lo;
    logic [XLEN-1:0] seq_pc, br_pc, jmp_pc, jr_pc, flow_pc;

    assign kernel   = pc_q[XLEN-1];
    assign irq_rise = irq & ~irq_dly_q;

    // Take decisions; both forced low while reset is asserted.
    assign excp_take_c = ~reset & illop & ~kernel;
    assign intr_take_c = ~reset & irq_pend_q & ~kernel & ~illop;

    // Target arithmetic is 31 bits wide so the kernel bit never carries in.
    assign seq_lo = pc_q[AW-1:0] + AW'(4);
    assign br_lo  = seq_lo + {br_off[AW-3:0], 2'b00};
    assign seq_pc = {kernel, seq_lo};
    assign br_pc  = {kernel, br_lo};
    assign jmp_pc = {kernel, seq_lo[AW-1:AW-3], jt, 2'b00};
    // User code cannot raise the kernel bit through JR; kernel code may drop it.
    assign jr_pc  = {kernel & rs_data[XLEN-1], rs_data[AW-1:0]};

    // Normal control-flow target chosen by the decoder.
    always_comb begin
        flow_pc = seq_pc;
        unique case (pcsrc)
            SRC_SEQ: flow_pc = seq_pc;
            SRC_BR:  flow_pc = br_taken ? br_pc : seq_pc;
            SRC_J:   flow_pc = jmp_pc;
            SRC_JR:  flow_pc = jr_pc;
            default: flow_pc = seq_pc;
        endcase
    end

    // Next-state selection: exception over interrupt over normal flow.
    always_comb begin
        pc_d       = flow_pc;
        irq_dly_d  = irq;
        // A fresh edge coinciding with the clear keeps the request pending.
        irq_pend_d = irq_rise | (irq_pend_q & ~intr_take_c);
        if (excp_take_c) begin
            pc_d = EXCP_VEC;
        end else if (intr_take_c) begin
            pc_d = INTR_VEC;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= RESET_VEC;
            irq_dly_q  <= 1'b0;
            irq_pend_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            irq_dly_q  <= irq_dly_d;
            irq_pend_q <= irq_pend_d;
        end
    end

    // Return address: the faulting instruction is skipped, the interrupted one re-runs.
    always_comb begin
        k0_wdata = '0;
        if (excp_take_c) begin
            k0_wdata = seq_pc;
        end else if (intr_take_c) begin
            k0_wdata = pc_q;
        end
    end

    assign pc        = pc_q;
    assign rom_addr  = pc_q[AW-1:0];
    assign pc_plus4  = seq_pc;
    assign intr_take = intr_take_c;
    assign excp_take = excp_take_c;

endmodule
